// File: rtl/mdu_controller.sv
// -----------------------------------------------------------------------------
// mdu_controller
//
// Multiply/divide unit controller for the five-stage MIPS pipeline. Accepts
// mult/multu/div/divu/mthi/mtlo from the E stage, holds the architectural
// HI/LO registers and runs a fixed-latency busy window for mult/div. Raises a
// stall request whenever the instruction in D needs the MDU while it is busy
// or is being started this cycle.
//
// Parameters:
//   MULT_CYCLES : busy window length for mult/multu (>= 1)
//   DIV_CYCLES  : busy window length for div/divu   (>= 1)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   start    in   E-stage MDU operation valid this cycle
//   md_op    in   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   rs_E     in   operand A / mthi, mtlo source
//   rt_E     in   operand B
//   md_D     in   instruction in D is an MDU instruction
//   hi       out  architectural HI register
//   lo       out  architectural LO register
//   busy     out  multi-cycle operation in progress (registered)
//   stall_md out  freeze D / bubble E request (combinational)
// -----------------------------------------------------------------------------
module mdu_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pending_hi_r;
    logic [31:0]      pending_lo_r;
    logic             pending_wr_r;
    logic             busy_r;

    logic [63:0]      op_result_s;   // {hi, lo} result of the E-stage operation
    logic             is_long_op_s;  // md_op is mult/multu/div/divu
    logic             div_zero_s;    // div/divu with a zero divisor
    logic [CNT_W-1:0] load_cnt_s;

    // 64-bit product; sign-extending to 64 bits makes one unsigned multiply
    // serve both the signed and unsigned forms.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
        logic [63:0] ext_a;
        logic [63:0] ext_b;
        ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ext_a * ext_b;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so the
    // quotient truncates toward zero and the remainder follows the dividend.
    // A zero divisor yields zero; that result is never committed.
    function automatic logic [63:0] div64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] abs_a;
        logic [31:0] abs_b;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        abs_a = neg_a ? (~a + 32'd1) : a;
        abs_b = neg_b ? (~b + 32'd1) : b;
        if (abs_b == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = abs_a / abs_b;
            r_mag = abs_a % abs_b;
        end
        q = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
        r = neg_a ? (~r_mag + 32'd1) : r_mag;
        return {r, q};
    endfunction

    // Decode the E-stage operation and compute its result.
    always_comb begin
        op_result_s  = 64'd0;
        is_long_op_s = ~md_op[2];
        div_zero_s   = md_op[1] & ~md_op[2] & (rt_E == 32'd0);
        if (md_op[1]) begin
            load_cnt_s = DIV_LOAD;
        end else begin
            load_cnt_s = MULT_LOAD;
        end
        case (md_op)
            OP_MULT:  op_result_s = mul64(rs_E, rt_E, 1'b1);
            OP_MULTU: op_result_s = mul64(rs_E, rt_E, 1'b0);
            OP_DIV:   op_result_s = div64(rs_E, rt_E, 1'b1);
            OP_DIVU:  op_result_s = div64(rs_E, rt_E, 1'b0);
            default:  op_result_s = 64'd0;
        endcase
    end

    // Control FSM, busy-window counter and HI/LO state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            hi_r         <= 32'd0;
            lo_r         <= 32'd0;
            pending_hi_r <= 32'd0;
            pending_lo_r <= 32'd0;
            pending_wr_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (is_long_op_s) begin
                            pending_hi_r <= op_result_s[63:32];
                            pending_lo_r <= op_result_s[31:0];
                            pending_wr_r <= ~div_zero_s;
                            cnt_r        <= load_cnt_s;
                            state_r      <= BUSY;
                            busy_r       <= 1'b1;
                        end else begin
                            case (md_op)
                                OP_MTHI: hi_r <= rs_E;
                                OP_MTLO: lo_r <= rs_E;
                                default: ;
                            endcase
                        end
                    end
                end
                BUSY: begin
                    // Starts seen here are ignored; the window runs to completion.
                    // A count of 0 cannot occur normally; treat it as the last
                    // cycle so the FSM can never lock up in BUSY.
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= '0;
                        if (pending_wr_r) begin
                            hi_r <= pending_hi_r;
                            lo_r <= pending_lo_r;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;
    // Combinational so the dependent instruction in D is held in the very
    // cycle the operation is issued.
    assign stall_md = md_D & (busy_r | (start & ~md_op[2]));

endmodule

// File: tb/tb_mdu_controller.sv
// -----------------------------------------------------------------------------
// tb_mdu_controller
//
// Self-checking bench for mdu_controller: table of operations with expected
// HI/LO, busy length and stall behaviour, plus hand-written sequences for
// reset, reset mid-operation and starts issued while busy.
// -----------------------------------------------------------------------------
module tb_mdu_controller;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
    localparam int NVEC        = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        md_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        md_d;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[NVEC];
    int   total = 0;
    int   bad   = 0;

    mdu_controller #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_E    (rs_E),
        .rt_E    (rt_E),
        .md_D    (md_D),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic d, input logic [31:0] eh, input logic [31:0] el,
                                input int ec);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.md_d = d;
        v.exp_hi = eh; v.exp_lo = el; v.exp_cycles = ec;
        return v;
    endfunction

    // Called just after a negedge with the DUT idle; returns just after the
    // negedge on which busy is seen low again (first idle cycle).
    task automatic run_op(input string name, input vec_t v);
        exp_t e;
        int   n;
        bit   stall_bad;
        e.hi = v.exp_hi; e.lo = v.exp_lo; e.cycles = v.exp_cycles;
        md_op = v.op; rs_E = v.rs; rt_E = v.rt; md_D = v.md_d; start = 1'b1;
        sb_q.push_back(e);
        #1;
        check32({name, "_stall_start"}, {31'd0, stall_md}, {31'd0, v.md_d & (v.op < 3'd4)});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        n = 0;
        stall_bad = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (stall_md !== v.md_d) stall_bad = 1'b1;
            @(negedge clk);
            #1;
        end
        e = sb_q.pop_front();
        check_int({name, "_busy_cycles"}, n, e.cycles);
        check32({name, "_hi"}, hi, e.hi);
        check32({name, "_lo"}, lo, e.lo);
        check32({name, "_stall_window"}, {31'd0, stall_bad}, 32'd0);
        check32({name, "_stall_idle"}, {31'd0, stall_md}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;

        vecs[0]  = mk(3'd0, 32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, MULT_CYCLES);
        vecs[1]  = mk(3'd1, 32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000001, 32'hFFFFFFFE, MULT_CYCLES);
        vecs[2]  = mk(3'd2, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYCLES);
        vecs[3]  = mk(3'd3, 32'd7,        32'd2,        1'b0, 32'h00000001, 32'h00000003, DIV_CYCLES);
        vecs[4]  = mk(3'd0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, MULT_CYCLES);
        vecs[5]  = mk(3'd1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 32'h80000000, MULT_CYCLES);
        vecs[6]  = mk(3'd2, 32'd7,        32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD, DIV_CYCLES);
        vecs[7]  = mk(3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFF, 32'h00000003, DIV_CYCLES);
        vecs[8]  = mk(3'd3, 32'hFFFFFFFF, 32'h00000010, 1'b1, 32'h0000000F, 32'h0FFFFFFF, DIV_CYCLES);
        vecs[9]  = mk(3'd4, 32'h12345678, 32'd0,        1'b1, 32'h12345678, 32'h0FFFFFFF, 0);
        vecs[10] = mk(3'd5, 32'h000000AA, 32'd0,        1'b0, 32'h12345678, 32'h000000AA, 0);
        vecs[11] = mk(3'd2, 32'd5,        32'd0,        1'b1, 32'h12345678, 32'h000000AA, DIV_CYCLES);
        vecs[12] = mk(3'd3, 32'd5,        32'd0,        1'b0, 32'h12345678, 32'h000000AA, DIV_CYCLES);
        vecs[13] = mk(3'd6, 32'd1,        32'd1,        1'b1, 32'h12345678, 32'h000000AA, 0);

        reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_E = 32'd0; rt_E = 32'd0; md_D = 1'b0;
        @(negedge clk);
        // Reset wins over an mthi issued in the same cycle.
        start = 1'b1; md_op = 3'd4; rs_E = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        #1;
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_stall", {31'd0, stall_md}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;

        // Table vectors back to back: each starts in the first idle cycle.
        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // Reset on the third busy cycle of a mult aborts it.
        md_op = 3'd0; rs_E = 32'd3; rt_E = 32'd4; md_D = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check32("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        #1;
        check32("abort_late_hi", hi, 32'd0);
        check32("abort_late_lo", lo, 32'd0);
        check32("abort_late_busy", {31'd0, busy}, 32'd0);

        // divu 7/2 with a mult and an mtlo issued mid-window; both ignored.
        e.hi = 32'd1; e.lo = 32'd3; e.cycles = DIV_CYCLES;
        sb_q.push_back(e);
        md_op = 3'd3; rs_E = 32'd7; rt_E = 32'd2; md_D = 1'b0; start = 1'b1;
        @(posedge clk);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = (k == 2) || (k == 4);
            md_op = (k == 2) ? 3'd0 : 3'd5;
            rs_E  = 32'h00000099;
            rt_E  = 32'hFFFFFFFF;
            #1;
            if (k == 5) check32("ignored_mtlo_lo", lo, 32'd0);
            if (busy !== 1'b1) break;
            n++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check_int("ignored_busy_cycles", n, e.cycles);
        check32("ignored_hi", hi, e.hi);
        check32("ignored_lo", lo, e.lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
